key_entry_ctrl: RTL and testbench

- Producer side of the ST/ST_L status interface consumed by the LED/segment display logic.
- Debounces raw keypad inputs and runs the code-entry state machine.
- Drives the 2-bit main state ST and the 3-bit digit-position sub-state ST_L.
- Compares entered digits against a stored code and reports success or failure.

---
 rtl/key_entry_ctrl_pkg.sv | 36 +++
 rtl/key_entry_ctrl_debounce.sv | 54 +++++
 rtl/key_entry_ctrl.sv | 145 ++++++++++++++
 tb/tb_key_entry_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_entry_ctrl_pkg.sv
// Shared state encodings and code-digit helper for the key entry controller
// and the display logic that decodes ST/ST_L.
package key_entry_ctrl_pkg;

  localparam int unsigned ST_W    = 2;
  localparam int unsigned STL_W   = 3;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CODE_W  = 16;

  typedef enum logic [ST_W-1:0] {
    S_IDLE = 2'd0,
    S_WPR  = 2'd1,
    S_OK   = 2'd2,
    S_ERR  = 2'd3
  } st_e;

  localparam logic [STL_W-1:0] SL_A = 3'd0;
  localparam logic [STL_W-1:0] SL_B = 3'd1;
  localparam logic [STL_W-1:0] SL_C = 3'd2;
  localparam logic [STL_W-1:0] SL_D = 3'd3;

  // Digit 0 lives in the most significant nibble.
  function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] code,
                                                    input logic [STL_W-1:0]  pos);
    logic [DIGIT_W-1:0] d;
    case (pos)
      SL_A:    d = code[15:12];
      SL_B:    d = code[11:8];
      SL_C:    d = code[7:4];
      SL_D:    d = code[3:0];
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/key_entry_ctrl_debounce.sv
// Raw key debouncer: the filtered level follows the input only after it has
// been stable for DEB_CYCLES samples; press is the filtered rising edge.
module key_debounce
  import key_entry_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             raw_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the filtered level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (raw_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = raw_q;
        press_d = raw_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q   <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      raw_q   <= raw_in;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/key_entry_ctrl.sv
// Code-entry controller: debounces the keypad and drives the ST/ST_L status
// consumed by the display, plus one-cycle success/failure pulses.
module key_entry_ctrl
  import key_entry_ctrl_pkg::*;
#(
  parameter int unsigned        DEB_CYCLES     = 16,
  parameter logic [CODE_W-1:0]  CODE           = 16'h1234,
  parameter int unsigned        CODE_LEN       = 4,
  parameter int unsigned        TIMEOUT_CYCLES = 1000,
  parameter int unsigned        RESULT_CYCLES  = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               key_clear,
  output logic [ST_W-1:0]    ST,
  output logic [STL_W-1:0]   ST_L,
  output logic               code_ok,
  output logic               code_err
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned      RES_W    = $clog2(RESULT_CYCLES + 1);
  localparam logic [STL_W-1:0] LAST_POS = STL_W'(CODE_LEN - 1);

  logic dig_level, dig_press;
  logic clr_level, clr_press;
  logic dig_ev, clr_ev, digit_match;

  st_e              state_q, state_d;
  logic [STL_W-1:0] stl_q, stl_d;
  logic             mis_q, mis_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_digit (
    .clk    (clk),
    .rst    (rst),
    .raw_in (key_valid),
    .level  (dig_level),
    .press  (dig_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk    (clk),
    .rst    (rst),
    .raw_in (key_clear),
    .level  (clr_level),
    .press  (clr_press)
  );

  // A press is only trusted while its filtered level is still asserted.
  assign dig_ev      = dig_press & dig_level;
  assign clr_ev      = clr_press & clr_level;
  assign digit_match = (key_code == code_digit(CODE, stl_q));

  always_comb begin
    state_d = state_q;
    stl_d   = stl_q;
    mis_d   = mis_q;
    tmo_d   = tmo_q;
    res_d   = res_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dig_ev) begin
          state_d = S_WPR;
          stl_d   = SL_A;
          mis_d   = 1'b0;
          tmo_d   = '0;
        end
      end
      S_WPR: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (clr_ev) begin
          stl_d = SL_A;
          mis_d = 1'b0;
          tmo_d = '0;
        end else if (dig_ev) begin
          tmo_d = '0;
          if (stl_q == LAST_POS) begin
            stl_d = SL_A;
            mis_d = 1'b0;
            res_d = '0;
            if (mis_q || !digit_match) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = S_OK;
              ok_d    = 1'b1;
            end
          end else begin
            stl_d = stl_q + STL_W'(1);
            mis_d = mis_q | ~digit_match;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          // Idle too long: force failure.
          state_d = S_ERR;
          err_d   = 1'b1;
          stl_d   = SL_A;
          mis_d   = 1'b0;
          res_d   = '0;
        end
      end
      S_OK, S_ERR: begin
        if (res_q == RES_W'(RESULT_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          res_d = res_q + RES_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stl_q   <= SL_A;
      mis_q   <= 1'b0;
      tmo_q   <= '0;
      res_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stl_q   <= stl_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
      res_q   <= res_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign ST       = state_q;
  assign ST_L     = stl_q;
  assign code_ok  = ok_q;
  assign code_err = err_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_key_entry_ctrl;

  localparam int DEB  = 4;
  localparam int TMO  = 40;
  localparam int RES  = 10;
  localparam int LEN  = 4;
  localparam int CODE = 'h1234;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_clear = 1'b0;
  logic [1:0] ST;
  logic [2:0] ST_L;
  logic       code_ok, code_err;

  key_entry_ctrl #(
    .DEB_CYCLES(DEB), .CODE(16'h1234), .CODE_LEN(LEN),
    .TIMEOUT_CYCLES(TMO), .RESULT_CYCLES(RES)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_clear(key_clear), .ST(ST), .ST_L(ST_L),
    .code_ok(code_ok), .code_err(code_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int        cyc = 0;
  bit        started = 1'b0;
  int        m_st, m_pos;
  bit        m_ok, m_err;
  int        t_last, t_enter;
  bit        v_lvl, c_lvl, pv, pc;
  bit        v_hist[$];
  bit        c_hist[$];
  bit [3:0]  entered[$];

  function automatic bit all_diff(input bit h[$], input bit lvl);
    if (h.size() < DEB) return 1'b0;
    for (int i = 0; i < DEB; i++)
      if (h[h.size() - 1 - i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit [3:0] ref_digit(input int i);
    return 4'((CODE >> (4 * (3 - i))) & 'hF);
  endfunction

  always @(posedge clk) begin
    bit npv, npc, good;
    cyc++;
    if (rst) begin
      started = 1'b1;
      m_st = 0; m_ok = 0; m_err = 0;
      entered.delete();
      v_lvl = 0; c_lvl = 0; pv = 0; pc = 0;
      v_hist.delete(); c_hist.delete();
      t_last = cyc; t_enter = cyc;
    end else begin
      m_ok = 0; m_err = 0;
      case (m_st)
        0: if (pv) begin m_st = 1; entered.delete(); t_last = cyc; end
        1: begin
          if (pc) begin
            entered.delete(); t_last = cyc;
          end else if (pv) begin
            entered.push_back(key_code); t_last = cyc;
            if (entered.size() == LEN) begin
              good = 1;
              for (int i = 0; i < LEN; i++) if (entered[i] != ref_digit(i)) good = 0;
              m_st = good ? 2 : 3; m_ok = good; m_err = !good;
              t_enter = cyc; entered.delete();
            end
          end else if (cyc - t_last == TMO) begin
            m_st = 3; m_err = 1; t_enter = cyc; entered.delete();
          end
        end
        default: if (cyc - t_enter == RES) m_st = 0;
      endcase
      npv = 0; npc = 0;
      if (all_diff(v_hist, v_lvl)) begin v_lvl = !v_lvl; npv = v_lvl; end
      if (all_diff(c_hist, c_lvl)) begin c_lvl = !c_lvl; npc = c_lvl; end
      v_hist.push_back(key_valid); if (v_hist.size() > 16) void'(v_hist.pop_front());
      c_hist.push_back(key_clear); if (c_hist.size() > 16) void'(c_hist.pop_front());
      pv = npv; pc = npc;
    end
    m_pos = entered.size();
  end

  // Per-cycle comparison against the model, plus pulse tallies.
  int ok_seen = 0, err_seen = 0, ok_cyc = 0;
  always @(negedge clk) begin
    if (started) begin
      check("ST", 8'(ST), 8'(m_st));
      check("ST_L", 8'(ST_L), 8'(m_pos));
      check("code_ok", 8'(code_ok), 8'(m_ok));
      check("code_err", 8'(code_err), 8'(m_err));
      if (code_ok === 1'b1) ok_seen++;
      if (code_err === 1'b1) err_seen++;
      if (ST === 2'd2) ok_cyc++;
    end
  end

  // ---------------- stimulus ----------------
  int e_cons;

  task automatic drive(input bit v, input bit c, input logic [3:0] d);
    @(negedge clk);
    key_valid = v; key_clear = c; key_code = d;
    e_cons = cyc + DEB + 2;
    repeat (6) @(negedge clk);
    key_valid = 0; key_clear = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d); drive(1, 0, d); endtask

  initial begin
    int ok0, err0, okc0, n;
    repeat (3) @(negedge clk);
    check("rst_ST", 8'(ST), 8'd0);
    check("rst_ST_L", 8'(ST_L), 8'd0);
    check("rst_ok", 8'(code_ok), 8'd0);
    check("rst_err", 8'(code_err), 8'd0);
    rst = 0;
    repeat (2) @(negedge clk);

    // Wake and correct code
    ok0 = ok_seen; okc0 = ok_cyc;
    press(4'd7);
    check("wake_ST", 8'(ST), 8'd1);
    check("wake_ST_L", 8'(ST_L), 8'd0);
    press(4'd1); check("pos1", 8'(ST_L), 8'd1);
    press(4'd2); check("pos2", 8'(ST_L), 8'd2);
    press(4'd3); check("pos3", 8'(ST_L), 8'd3);
    press(4'd4);
    repeat (6) @(negedge clk);
    check("ok_pulses", 8'(ok_seen - ok0), 8'd1);
    check("ok_hold_cycles", 8'(ok_cyc - okc0), 8'd10);
    check("ok_back_idle", 8'(ST), 8'd0);

    // Wrong digit
    ok0 = ok_seen; err0 = err_seen;
    press(4'd0); press(4'd1); press(4'd9); press(4'd3);
    check("wrong_pos3", 8'(ST_L), 8'd3);
    press(4'd4);
    repeat (6) @(negedge clk);
    check("wrong_err", 8'(err_seen - err0), 8'd1);
    check("wrong_no_ok", 8'(ok_seen - ok0), 8'd0);

    // Bounce rejection and latency
    err0 = err_seen;
    @(negedge clk) key_valid = 1; key_code = 4'd5;
    @(negedge clk) key_valid = 0;
    @(negedge clk) key_valid = 1;
    @(negedge clk) key_valid = 0;
    @(negedge clk) key_valid = 1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ST == 2'd1) begin n = k; break; end
    end
    check("bounce_latency", 8'(n - 1), 8'(DEB + 1));
    repeat (100) @(negedge clk);
    check("hold_ST", 8'(ST), 8'd0);
    check("hold_err", 8'(err_seen - err0), 8'd1);
    key_valid = 0;
    repeat (8) @(negedge clk);

    // Clear mid-entry, then correct code
    ok0 = ok_seen;
    press(4'd0); press(4'd1); press(4'd2);
    drive(0, 1, 4'd0);
    check("clr_ST_L", 8'(ST_L), 8'd0);
    check("clr_ST", 8'(ST), 8'd1);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("clr_then_ok", 8'(ok_seen - ok0), 8'd1);
    repeat (12) @(negedge clk);

    // Clear and digit on the same cycle
    press(4'd0); press(4'd1);
    drive(1, 1, 4'd2);
    check("both_ST_L", 8'(ST_L), 8'd0);
    check("both_ST", 8'(ST), 8'd1);
    ok0 = ok_seen;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("both_then_ok", 8'(ok_seen - ok0), 8'd1);
    repeat (12) @(negedge clk);

    // Timeout
    err0 = err_seen;
    press(4'd0); press(4'd1);
    n = e_cons;
    for (int k = 0; k < 100 && cyc < n + 45; k++) @(negedge clk);
    check("tmo_ST", 8'(ST), 8'd3);
    check("tmo_ST_L", 8'(ST_L), 8'd0);
    check("tmo_err", 8'(err_seen - err0), 8'd1);
    repeat (12) @(negedge clk);

    // Press on the expiry cycle wins
    err0 = err_seen;
    press(4'd0); press(4'd1);
    n = e_cons;
    for (int k = 0; k < 100 && cyc < n + TMO - DEB - 3; k++) @(negedge clk);
    press(4'd2);
    check("expiry_cons_edge", 8'(e_cons - n), 8'(TMO));
    check("expiry_ST", 8'(ST), 8'd1);
    check("expiry_ST_L", 8'(ST_L), 8'd2);
    check("expiry_no_err", 8'(err_seen - err0), 8'd0);

    // Reset mid-entry (ST_L is 2 here)
    ok0 = ok_seen; err0 = err_seen;
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    check("rstmid_ST", 8'(ST), 8'd0);
    check("rstmid_ST_L", 8'(ST_L), 8'd0);
    repeat (5) @(negedge clk);
    check("rstmid_no_ok", 8'(ok_seen - ok0), 8'd0);
    check("rstmid_no_err", 8'(err_seen - err0), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
